// File: rtl/seg7_scan_decoder.sv
// Seven-segment scan decoder: debounces multiplexed {dig_sel, seg} samples and
// assembles ones/tens digits into BCD and binary frames with a sticky error flag.
module seg7_scan_decoder #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [6:0] seg,
  input  logic [1:0] dig_sel,
  input  logic       clr_err,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic [6:0] bin_val,
  output logic       valid,
  output logic       err
);

  localparam logic [3:0] LP_STABLE = 4'(STABLE_CYCLES);
  localparam logic [3:0] LP_PRE    = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ONES, WAIT_TENS, REPORT} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [8:0] r_sample;
  logic [3:0] r_hold;
  logic [3:0] r_ones_pend;
  logic [3:0] r_bcd_tens;
  logic [3:0] r_bcd_ones;
  logic       r_valid;
  logic       r_err;

  logic [8:0] w_key;
  logic       w_same;
  logic       w_accept;
  logic [3:0] w_digit;
  logic       w_legal;
  logic       w_blank;
  logic       w_store_ones;
  logic       w_report;
  logic       w_set_err;

  assign w_key  = {dig_sel, seg};
  assign w_same = (w_key == r_sample);
  // Accept fires only on the edge where the hold count steps into saturation.
  assign w_accept = w_same && (r_hold == LP_PRE) &&
                    ((dig_sel == 2'b01) || (dig_sel == 2'b10));

  always_comb begin
    w_digit = '0;
    w_legal = 1'b1;
    w_blank = 1'b0;
    case (seg)
      7'b1000000: w_digit = 4'd0;
      7'b1111001: w_digit = 4'd1;
      7'b0100100: w_digit = 4'd2;
      7'b0110000: w_digit = 4'd3;
      7'b0011001: w_digit = 4'd4;
      7'b0010010: w_digit = 4'd5;
      7'b0000010: w_digit = 4'd6;
      7'b1111000: w_digit = 4'd7;
      7'b0000000: w_digit = 4'd8;
      7'b0010000: w_digit = 4'd9;
      7'b1111111: begin
        w_legal = 1'b0;
        w_blank = 1'b1;
      end
      default:    w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_next       = r_state;
    w_store_ones = 1'b0;
    w_report     = 1'b0;
    w_set_err    = 1'b0;
    if (!en) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:      w_next = WAIT_ONES;
        WAIT_ONES: begin
          if (w_accept && (dig_sel == 2'b01)) begin
            if (w_legal) begin
              w_store_ones = 1'b1;
              w_next       = WAIT_TENS;
            end else begin
              w_set_err = 1'b1;
            end
          end
        end
        WAIT_TENS: begin
          if (w_accept) begin
            if (dig_sel == 2'b10) begin
              // A blank tens digit is a suppressed leading zero.
              if (w_legal || w_blank) begin
                w_report = 1'b1;
                w_next   = REPORT;
              end else begin
                w_set_err = 1'b1;
                w_next    = WAIT_ONES;
              end
            end else if (w_legal) begin
              w_store_ones = 1'b1;
            end else begin
              w_set_err = 1'b1;
              w_next    = WAIT_ONES;
            end
          end
        end
        REPORT:    w_next = WAIT_ONES;
        default:   w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sample    <= {2'b00, 7'b1111111};
      r_hold      <= '0;
      r_ones_pend <= '0;
      r_bcd_tens  <= '0;
      r_bcd_ones  <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_sample <= w_key;
      if (!w_same) begin
        r_hold <= 4'd1;
      end else if (r_hold != LP_STABLE) begin
        r_hold <= r_hold + 4'd1;
      end
      if (w_store_ones) begin
        r_ones_pend <= w_digit;
      end
      // Outputs load on the edge entering REPORT so they are visible with valid.
      r_valid <= w_report;
      if (w_report) begin
        r_bcd_tens <= w_digit;
        r_bcd_ones <= r_ones_pend;
      end
      r_err <= w_set_err | (r_err & ~clr_err);
    end
  end

  assign bcd_tens = r_bcd_tens;
  assign bcd_ones = r_bcd_ones;
  assign valid    = r_valid;
  assign err      = r_err;
  // tens*10 = tens*8 + tens*2; digits are at most 9 so the sum stays within 7 bits.
  assign bin_val  = {r_bcd_tens, 3'b000} + {2'b00, r_bcd_tens, 1'b0} + {3'b000, r_bcd_ones};

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: directed frame table, corner
// sequences and randomized scan traffic against a behavioural model.
module tb_seg7_scan_decoder;

  localparam int unsigned STABLE = 4;
  localparam logic [6:0] PATS [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                       7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam logic [6:0] BLANK = 7'h7F;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [6:0] seg;
  logic [1:0] dig_sel;
  logic       clr_err;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic [6:0] bin_val;
  logic       valid;
  logic       err;

  int checks   = 0;
  int failures = 0;
  int vcount   = 0;

  logic [8:0] m_prev;
  int         m_run;
  bit         m_active;
  int         m_ones;
  bit         m_rep;
  int         m_tens_o;
  int         m_ones_o;
  bit         m_err;

  typedef struct {
    logic [6:0] ones_seg;
    int         ones_hold;
    logic [6:0] tens_seg;
    int         tens_hold;
    int         exp_valid;
    int         exp_tens;
    int         exp_ones;
    int         exp_err;
  } vec_t;

  vec_t vecs [10];

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .seg      (seg),
    .dig_sel  (dig_sel),
    .clr_err  (clr_err),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .bin_val  (bin_val),
    .valid    (valid),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [6:0] s);
    for (int i = 0; i < 10; i++) begin
      if (s == PATS[i]) return i;
    end
    if (s == BLANK) return 10;
    return -1;
  endfunction

  task automatic model_reset();
    m_prev   = {2'b00, BLANK};
    m_run    = 0;
    m_active = 1'b0;
    m_ones   = -1;
    m_rep    = 1'b0;
    m_tens_o = 0;
    m_ones_o = 0;
    m_err    = 1'b0;
  endtask

  // One clock edge of the reference: run-length debounce, then frame assembly.
  task automatic model_step();
    logic [8:0] key;
    bit acc, was_rep, set_err;
    int d;
    key = {dig_sel, seg};
    m_run = (key == m_prev) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    m_prev = key;
    acc = (m_run == int'(STABLE)) && (dig_sel == 2'b01 || dig_sel == 2'b10);
    d = decode(seg);
    was_rep = m_rep;
    m_rep = 1'b0;
    set_err = 1'b0;
    if (!en) begin
      m_active = 1'b0;
      m_ones = -1;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_ones = -1;
    end else if (was_rep) begin
      m_ones = -1;
    end else if (acc) begin
      if (dig_sel == 2'b01) begin
        if (d >= 0 && d <= 9) m_ones = d;
        else begin
          set_err = 1'b1;
          m_ones = -1;
        end
      end else if (m_ones >= 0) begin
        if (d < 0) begin
          set_err = 1'b1;
        end else begin
          m_tens_o = (d == 10) ? 0 : d;
          m_ones_o = m_ones;
          m_rep = 1'b1;
        end
        m_ones = -1;
      end
    end
    if (set_err) m_err = 1'b1;
    else if (clr_err) m_err = 1'b0;
  endtask

  task automatic compare_model();
    chk("model_valid", int'(valid), int'(m_rep));
    chk("model_tens", int'(bcd_tens), m_tens_o);
    chk("model_ones", int'(bcd_ones), m_ones_o);
    chk("model_bin", int'(bin_val), m_tens_o * 10 + m_ones_o);
    chk("model_err", int'(err), int'(m_err));
  endtask

  task automatic cyc(input logic e, input logic [6:0] s, input logic [1:0] d, input logic c);
    en = e;
    seg = s;
    dig_sel = d;
    clr_err = c;
    @(posedge clk);
    model_step();
    #1;
    compare_model();
    if (valid) vcount++;
  endtask

  task automatic hold(input logic [6:0] s, input logic [1:0] d, input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, s, d, 1'b0);
  endtask

  task automatic sep();
    cyc(1'b1, BLANK, 2'b00, 1'b1);
    cyc(1'b1, BLANK, 2'b00, 1'b1);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_tens"}, int'(bcd_tens), 0);
    chk({tag, "_ones"}, int'(bcd_ones), 0);
    chk({tag, "_bin"}, int'(bin_val), 0);
    chk({tag, "_valid"}, int'(valid), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    seg = BLANK;
    dig_sel = 2'b00;
    clr_err = 1'b0;
    model_reset();
    #1;
    check_zero_outputs("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{7'h78, 4, 7'h19, 4, 1, 4, 7, 0};
    vecs[1] = '{7'h00, 4, 7'h79, 4, 1, 1, 8, 0};
    vecs[2] = '{7'h12, 4, BLANK, 4, 1, 0, 5, 0};
    vecs[3] = '{7'h36, 4, 7'h30, 4, 0, 0, 5, 1};
    vecs[4] = '{7'h10, 4, 7'h10, 4, 1, 9, 9, 0};
    vecs[5] = '{7'h12, 3, 7'h24, 4, 0, 9, 9, 0};
    vecs[6] = '{BLANK, 4, 7'h02, 4, 0, 9, 9, 1};
    vecs[7] = '{7'h40, 4, 7'h7E, 4, 0, 9, 9, 1};
    vecs[8] = '{7'h24, 4, 7'h02, 4, 1, 6, 2, 0};
    vecs[9] = '{7'h40, 4, 7'h40, 4, 1, 0, 0, 0};

    sep();
    for (int i = 0; i < 10; i++) begin
      vcount = 0;
      hold(vecs[i].ones_seg, 2'b01, vecs[i].ones_hold);
      hold(vecs[i].tens_seg, 2'b10, vecs[i].tens_hold);
      chk($sformatf("vec%0d_valid_count", i), vcount, vecs[i].exp_valid);
      chk($sformatf("vec%0d_tens", i), int'(bcd_tens), vecs[i].exp_tens);
      chk($sformatf("vec%0d_ones", i), int'(bcd_ones), vecs[i].exp_ones);
      chk($sformatf("vec%0d_bin", i), int'(bin_val), vecs[i].exp_tens * 10 + vecs[i].exp_ones);
      chk($sformatf("vec%0d_err", i), int'(err), vecs[i].exp_err);
      sep();
    end

    // Short hold of 5 must not be taken; the following 8 is.
    vcount = 0;
    hold(7'h12, 2'b01, 3);
    hold(7'h00, 2'b01, 4);
    hold(7'h79, 2'b10, 4);
    chk("short_hold_valid", vcount, 1);
    chk("short_hold_ones", int'(bcd_ones), 8);
    chk("short_hold_bin", int'(bin_val), 18);
    sep();

    // Illegal pattern sets err; clear alone, then set-wins-over-clear.
    vcount = 0;
    hold(7'h36, 2'b01, 4);
    chk("illegal_err_set", int'(err), 1);
    chk("illegal_no_valid", vcount, 0);
    cyc(1'b1, BLANK, 2'b00, 1'b1);
    chk("clr_err_clears", int'(err), 0);
    hold(7'h36, 2'b01, 3);
    cyc(1'b1, 7'h36, 2'b01, 1'b1);
    chk("set_wins_over_clr", int'(err), 1);
    cyc(1'b1, BLANK, 2'b00, 1'b0);
    chk("err_sticky", int'(err), 1);
    cyc(1'b1, BLANK, 2'b00, 1'b1);
    chk("err_cleared_again", int'(err), 0);

    // en drop between ones and tens discards the partial frame.
    vcount = 0;
    hold(7'h30, 2'b01, 4);
    cyc(1'b0, BLANK, 2'b00, 1'b0);
    hold(7'h24, 2'b10, 4);
    chk("en_drop_no_valid", vcount, 0);
    chk("en_drop_bin_kept", int'(bin_val), 18);
    sep();

    // en=0 coinciding with the tens accept edge wins.
    vcount = 0;
    hold(7'h19, 2'b01, 4);
    hold(7'h02, 2'b10, 3);
    cyc(1'b0, 7'h02, 2'b10, 1'b0);
    chk("en_wins_no_valid", vcount, 0);
    chk("en_wins_bin_kept", int'(bin_val), 18);
    sep();

    // Reset mid-frame, then a full 9/9 frame after en is seen.
    hold(7'h36, 2'b01, 4);
    hold(7'h10, 2'b01, 4);
    chk("pre_reset_err", int'(err), 1);
    do_reset();
    vcount = 0;
    cyc(1'b0, BLANK, 2'b00, 1'b0);
    cyc(1'b0, BLANK, 2'b00, 1'b0);
    hold(7'h10, 2'b01, 4);
    hold(7'h10, 2'b10, 4);
    chk("post_reset_valid", vcount, 1);
    chk("post_reset_bin", int'(bin_val), 99);
    sep();

    // Randomized scan traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [6:0] s;
      logic [1:0] d;
      int k, h;
      k = $urandom_range(0, 9);
      if (k <= 6) s = PATS[$urandom_range(0, 9)];
      else if (k == 7) s = BLANK;
      else s = 7'($urandom);
      k = $urandom_range(0, 5);
      d = (k < 2) ? 2'b01 : (k < 4) ? 2'b10 : (k == 4) ? 2'b00 : 2'b11;
      h = $urandom_range(1, STABLE + 2);
      for (int j = 0; j < h; j++) begin
        cyc(logic'($urandom_range(0, 39) != 0), s, d, logic'($urandom_range(0, 11) == 0));
      end
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples required to accept a digit (legal range 2..15).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 en  input  1  capture enable; low forces the idle state.
REQ-005 seg  input  7  active-low segment pattern, bit order {g,f,e,d,c,b,a}.
REQ-006 dig_sel  input  2  scan strobe: 2'b01 = ones digit, 2'b10 = tens digit, 2'b00/2'b11 = no digit.
REQ-007 clr_err  input  1  synchronous clear of the sticky error flag.
REQ-008 bcd_tens  output  4  last reported tens digit (0..9).
REQ-009 bcd_ones  output  4  last reported ones digit (0..9).
REQ-010 bin_val  output  7  last reported value as binary, bcd_tens*10+bcd_ones (0..99).
REQ-011 valid  output  1  one-cycle pulse when a new frame is reported.
REQ-012 err  output  1  sticky illegal-pattern flag.

Function
REQ-013 Legal patterns SHALL be 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; blank=1111111; every other code is illegal.
REQ-014 A sample register SHALL capture {dig_sel, seg} every cycle; a saturating hold counter SHALL load 1 when the new sample differs from the stored one, else increment (saturating at STABLE_CYCLES).
REQ-015 An accept event SHALL occur only on the edge at which the hold counter reaches STABLE_CYCLES, once per hold, and only when dig_sel is 2'b01 or 2'b10.
REQ-016 FSM states: IDLE, WAIT_ONES, WAIT_TENS, REPORT.
REQ-017 IDLE -> WAIT_ONES when en=1; otherwise remain.
REQ-018 WAIT_ONES: accept with dig_sel=01 and legal digit stores ones, -> WAIT_TENS; accepts with dig_sel=10 are ignored.
REQ-019 WAIT_TENS: accept with dig_sel=10 stores tens, -> REPORT; accept with dig_sel=01 overwrites stored ones, stays.
REQ-020 Blank on tens SHALL decode as 0 (leading blank); blank on ones SHALL be treated as illegal.
REQ-021 Accept of an illegal pattern SHALL set err, discard the partial frame, and go to WAIT_ONES.
REQ-022 REPORT lasts exactly one cycle: bcd_tens, bcd_ones, bin_val update and valid=1 in that cycle; next state WAIT_ONES (IDLE if en=0).
REQ-023 Latency: valid asserts one cycle after the tens accept edge.
REQ-024 Outputs bcd_tens/bcd_ones/bin_val SHALL hold their last reported value between reports and across en=0.
REQ-025 en=0 in any state SHALL force IDLE on the next edge, discarding any partial frame; en=0 wins over a simultaneous accept.
REQ-026 err set and clr_err in the same cycle: set wins; clr_err alone clears err on the next edge.
REQ-027 bin_val SHALL be computed from the registered BCD digits without exceeding 7 bits (max 99).

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, hold counter=0, sample register=all ones with dig_sel=00, bcd_tens=0, bcd_ones=0, bin_val=0, valid=0, err=0.
REQ-029 Reset deassertion mid-frame SHALL restart capture from WAIT_ONES only after en=1 is seen in IDLE.

Verification
REQ-030 en=1; seg=1111000, dig_sel=01 for 4 cycles; then seg=0011001, dig_sel=10 for 4 cycles -> valid one cycle, bcd_tens=4, bcd_ones=7, bin_val=47, err=0.
REQ-031 seg=0010010 dig_sel=01 held 3 cycles then changed to 0000000 held 4 cycles -> ones=8 captured, 5 never accepted.
REQ-032 ones=5 accepted, then tens seg=1111111 dig_sel=10 held 4 cycles -> valid, bin_val=5, bcd_tens=0.
REQ-033 seg=0110110 dig_sel=01 held 4 cycles -> err=1, no valid; clr_err pulse -> err=0 next edge.
REQ-034 ones=3 accepted, en dropped for 1 cycle, then tens=2 accepted -> no valid; outputs keep prior values.
REQ-035 rst_n asserted between ones and tens accept -> all outputs 0 immediately; subsequent full frame 9/9 -> bin_val=99.
